// File: rtl/pdm_audio_cfg_pkg.sv
// Shared types for the pdm_audio bring-up configuration sequencer.
//   state_t    : sequencer FSM states
//   err_code_t : abort reason reported on err_code
package pdm_audio_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWresp,
    StRd,
    StRdata,
    StDone,
    StErr
  } state_t;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrResp     = 2'd1,
    ErrMismatch = 2'd2,
    ErrTimeout  = 2'd3
  } err_code_t;

  localparam logic [1:0] AxiRespOkay = 2'b00;
  localparam int unsigned TimerW = 16;
  localparam int unsigned IdxW = 4;

endpackage

// File: rtl/pdm_audio_cfg_seq.sv
// AXI4-Lite master that programs the pdm_audio register bank at bring-up.
// On start it writes NUM_REGS words from INIT_DATA to BASE_ADDR + 4*i, then reads
// every register back and compares it with the value written. Status is sticky.
// Ports:
//   ACLK, ARESETN        clock, async active-low reset
//   start                1-cycle pulse, accepted only when idle
//   busy/done/error      status; done/error sticky until the next accepted start
//   err_code, err_index  abort reason and register index of the abort
//   m_aw*/m_w*/m_b*      AXI4-Lite write channels
//   m_ar*/m_r*           AXI4-Lite read channels
module pdm_audio_cfg_seq
  import pdm_audio_cfg_pkg::*;
#(
  parameter int unsigned             NUM_REGS       = 4,
  parameter logic [31:0]             BASE_ADDR      = 32'h0000_0000,
  parameter logic [NUM_REGS*32-1:0]  INIT_DATA      = {32'h4, 32'h3, 32'h2, 32'h1},
  parameter int unsigned             TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  err_index,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [IdxW-1:0]   LastIdx     = IdxW'(NUM_REGS - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_code_t         err_code_q, err_code_d;
  logic [IdxW-1:0]   err_index_q, err_index_d;
  logic [TimerW-1:0] cnt_q, cnt_d;

  logic              fail;
  err_code_t         fail_code;
  logic              timeout;
  logic              waiting;
  logic [31:0]       addr;
  logic [31:0]       init_words [16];

  // Unpack INIT_DATA into a fixed 16-entry table so idx_q can index it directly.
  for (genvar i = 0; i < 16; i++) begin : g_words
    if (i < NUM_REGS) begin : g_used
      assign init_words[i] = INIT_DATA[32*i +: 32];
    end else begin : g_unused
      assign init_words[i] = '0;
    end
  end

  // idx_q only moves on completed handshakes, so the address is stable while valid is high.
  assign addr    = BASE_ADDR + {{(32 - IdxW - 2){1'b0}}, idx_q, 2'b00};
  assign timeout = (cnt_q >= TimeoutLast);
  assign waiting = (state_q == StWr) || (state_q == StWresp) ||
                   (state_q == StRd) || (state_q == StRdata);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    fail        = 1'b0;
    fail_code   = ErrNone;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ErrNone;
          idx_d      = '0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_d    = StWr;
        end
      end
      StWr: begin
        // AW and W complete independently; a dropped valid means that channel is done.
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
          state_d = StWresp;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StWresp: begin
        if (m_bvalid) begin
          if (m_bresp != AxiRespOkay) begin
            fail      = 1'b1;
            fail_code = ErrResp;
          end else if (idx_q == LastIdx) begin
            idx_d     = '0;
            arvalid_d = 1'b1;
            state_d   = StRd;
          end else begin
            idx_d     = idx_q + 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StRd: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = StRdata;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StRdata: begin
        if (m_rvalid) begin
          if (m_rresp != AxiRespOkay) begin
            fail      = 1'b1;
            fail_code = ErrResp;
          end else if (m_rdata != init_words[idx_q]) begin
            fail      = 1'b1;
            fail_code = ErrMismatch;
          end else if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d     = idx_q + 1'b1;
            arvalid_d = 1'b1;
            state_d   = StRd;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        error_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort path: report the failing index and withdraw every request.
    if (fail) begin
      state_d     = StErr;
      err_code_d  = fail_code;
      err_index_d = idx_q;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
    end

    // Wait counter restarts on every state change, including WRESP->WR and RDATA->RD.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ErrNone;
      err_index_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;

  assign m_awaddr  = addr;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = init_words[idx_q];
  assign m_wstrb   = 4'hF;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = (state_q == StWresp);
  assign m_araddr  = addr;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = (state_q == StRdata);

endmodule

// File: tb/tb_pdm_audio_cfg_seq.sv
// Directed bench for pdm_audio_cfg_seq with a small AXI4-Lite slave register model.
module tb_pdm_audio_cfg_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  err_index;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int total = 0;
  int bad = 0;

  pdm_audio_cfg_seq dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .err_index (err_index),
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model configuration (driven by the stimulus block) ----------------
  logic        rand_mode = 1'b0;
  int unsigned cfg_aw_stall = 0, cfg_w_stall = 0, cfg_ar_stall = 0;
  int          slverr_idx = -1;
  int          force_idx = -1;

  // ---------------- slave model state ----------------
  logic [31:0] mem [16];
  int unsigned aw_cnt, w_cnt, ar_cnt;
  int unsigned aw_rnd, w_rnd, ar_rnd;
  int unsigned aw_lim, w_lim, ar_lim;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  int unsigned ar_seen;

  wire         aw_hs   = m_awvalid & m_awready;
  wire         w_hs    = m_wvalid & m_wready;
  wire         ar_hs   = m_arvalid & m_arready;
  wire  [31:0] wr_addr = aw_hs ? m_awaddr : aw_addr_q;
  wire  [31:0] wr_data = w_hs ? m_wdata : w_data_q;

  assign aw_lim = rand_mode ? aw_rnd : cfg_aw_stall;
  assign w_lim  = rand_mode ? w_rnd : cfg_w_stall;
  assign ar_lim = rand_mode ? ar_rnd : cfg_ar_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_awready <= 1'b0; m_wready <= 1'b0; m_arready <= 1'b0;
      m_bvalid <= 1'b0; m_bresp <= 2'b00;
      m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_rnd <= 0; w_rnd <= 0; ar_rnd <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_q <= '0; w_data_q <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (m_arvalid) ar_seen <= ar_seen + 1;
      // AW
      if (aw_hs) begin
        m_awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1; aw_addr_q <= m_awaddr;
        aw_rnd <= $urandom_range(0, 10);
      end else if (m_awvalid && !m_awready && !aw_got) begin
        if (aw_cnt >= aw_lim) m_awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      // W
      if (w_hs) begin
        m_wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1; w_data_q <= m_wdata;
        w_rnd <= $urandom_range(0, 10);
      end else if (m_wvalid && !m_wready && !w_got) begin
        if (w_cnt >= w_lim) m_wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      // B: respond as soon as both halves of the write are in
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[wr_addr[5:2]] <= wr_data;
        m_bvalid <= 1'b1;
        m_bresp  <= (int'(wr_addr[5:2]) == slverr_idx) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
      end
      // AR / R
      if (ar_hs) begin
        m_arready <= 1'b0; ar_cnt <= 0;
        ar_rnd <= $urandom_range(0, 10);
        m_rvalid <= 1'b1; m_rresp <= 2'b00;
        m_rdata  <= (int'(m_araddr[5:2]) == force_idx) ? 32'hDEAD : mem[m_araddr[5:2]];
      end else begin
        if (m_arvalid && !m_arready) begin
          if (ar_cnt >= ar_lim) m_arready <= 1'b1;
          else ar_cnt <= ar_cnt + 1;
        end
        if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      end
    end
  end

  initial ar_seen = 0;

  // AW/W must stay valid with a stable payload until accepted.
  logic        p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_awaddr, p_wdata;
  int          proto_err = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0;
    end else begin
      if (p_awv && !p_awr && (!m_awvalid || m_awaddr != p_awaddr)) proto_err <= proto_err + 1;
      if (p_wv && !p_wr && (!m_wvalid || m_wdata != p_wdata))      proto_err <= proto_err + 1;
      p_awv <= m_awvalid; p_awr <= m_awready; p_awaddr <= m_awaddr;
      p_wv <= m_wvalid;   p_wr <= m_wready;   p_wdata <= m_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start and wait (bounded) for done or error. Also returns status one cycle after start.
  task automatic run_seq(output int cyc, output logic s_done, output logic s_err,
                         output logic [1:0] s_code, output logic s_busy);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    s_done = done; s_err = error; s_code = err_code; s_busy = busy;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int         cyc;
  logic       s_done, s_err, s_busy;
  logic [1:0] s_code;
  int unsigned ar0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_index", 32'(err_index), 32'd0);
    check("rst_valids", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait slave
    run_seq(cyc, s_done, s_err, s_code, s_busy);
    check("t1_busy_after_start", 32'(s_busy), 32'd1);
    check("t1_latency", 32'(cyc), 32'd26);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("t1_mem%0d", i), mem[i], 32'(i + 1));
    check("t1_wstrb_prot", {25'd0, m_wstrb, m_awprot}, {25'd0, 4'hF, 3'b000});

    // 2: random stalls and AW/W ordering
    do_reset();
    rand_mode = 1'b1;
    run_seq(cyc, s_done, s_err, s_code, s_busy);
    check("t2_done", 32'(done), 32'd1);
    check("t2_error", 32'(error), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("t2_mem%0d", i), mem[i], 32'(i + 1));
    check("t2_protocol", 32'(proto_err), 32'd0);
    rand_mode = 1'b0;

    // 3: SLVERR on write of reg 2, no read issued
    do_reset();
    slverr_idx = 2;
    ar0 = ar_seen;
    run_seq(cyc, s_done, s_err, s_code, s_busy);
    check("t3_error", 32'(error), 32'd1);
    check("t3_code", 32'(err_code), 32'd1);
    check("t3_index", 32'(err_index), 32'd2);
    check("t3_done", 32'(done), 32'd0);
    check("t3_no_ar", ar_seen - ar0, 32'd0);
    slverr_idx = -1;

    // 4: reg1 reads back 32'hDEAD; no reset, so start must clear the previous error
    force_idx = 1;
    run_seq(cyc, s_done, s_err, s_code, s_busy);
    check("t4_err_cleared", 32'(s_err), 32'd0);
    check("t4_code_cleared", 32'(s_code), 32'd0);
    check("t4_error", 32'(error), 32'd1);
    check("t4_code", 32'(err_code), 32'd2);
    check("t4_index", 32'(err_index), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    force_idx = -1;

    // 5: arready stuck low; extra start during busy is ignored
    do_reset();
    cfg_ar_stall = 300;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 50);
    end
    start = 1'b0;
    check("t5_latency", 32'(cyc), 32'd270);
    check("t5_code", 32'(err_code), 32'd3);
    check("t5_index", 32'(err_index), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_arvalid_dropped", 32'(m_arvalid), 32'd0);
    do_reset();
    cfg_ar_stall = 0;

    // 6: reset in the middle of a write, then a clean run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_in_wr", {30'd0, m_awvalid, m_wvalid}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valids_drop", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
    check("t6_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(cyc, s_done, s_err, s_code, s_busy);
    check("t6_done", 32'(done), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    check("t6_latency", 32'(cyc), 32'd26);
    check("t6_mem3", mem[3], 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
